// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: state encoding and instruction-memory geometry.
// Decode and the benches import this too, so keep it free of fetch internals.
package fetch_pkg;

  localparam int          IMEM_AWIDTH       = 6;
  localparam int          IMEM_RWIDTH       = 32;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, reads an async-read instruction memory and
// hands registered {instr, pc} pairs to decode over a valid/ready handshake.
// Redirects flush the output slot; a halt word stops fetch until a redirect.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                AWIDTH    = IMEM_AWIDTH,
  parameter int                RWIDTH    = IMEM_RWIDTH,
  parameter int                RESET_PC  = 0,
  parameter logic [RWIDTH-1:0] HALT_WORD = RWIDTH'(HALT_WORD_DEFAULT),
  parameter int                CWIDTH    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [AWIDTH-1:0] imem_addr,
  input  logic [RWIDTH-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_addr,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [RWIDTH-1:0] if_instr,
  output logic [AWIDTH-1:0] if_pc,
  output logic              halted,
  output logic [CWIDTH-1:0] fetch_count
);

  localparam logic [AWIDTH-1:0] PC_INIT = AWIDTH'(RESET_PC);
  localparam logic [CWIDTH-1:0] CNT_MAX = '1;

  fetch_state_t      state;
  logic [AWIDTH-1:0] pc;
  logic              slot_free;
  logic              handshake;

  // The memory is addressed straight from the PC register; no extra stage.
  assign imem_addr = pc;

  // Output slot can take a new word when empty or being drained this cycle.
  assign slot_free = !if_valid || if_ready;
  assign handshake = if_valid && if_ready;

  // Delivered-instruction counter, saturating so long runs never alias to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (handshake && (fetch_count != CNT_MAX)) begin
      fetch_count <= fetch_count + 1'b1;
    end
  end

  // Fetch FSM: redirect beats everything; RUN captures when the slot is free;
  // HALTED only lets the last word drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      halted   <= 1'b0;
      pc       <= PC_INIT;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (redirect_valid) begin
      // Any pending word is dropped; an accepted one was already counted.
      state    <= RUN;
      halted   <= 1'b0;
      pc       <= redirect_addr;
      if_valid <= 1'b0;
    end else if (state == RUN) begin
      if (slot_free) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
        if_valid <= 1'b1;
        pc       <= pc + 1'b1;
        // The halt word itself is still delivered to decode.
        if (imem_rdata == HALT_WORD) begin
          state  <= HALTED;
          halted <= 1'b1;
        end
      end
    end else begin
      // HALTED: no captures; clear valid once the last word is taken.
      if (if_ready) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: stream, stall, redirect, halt, async
// reset and counter saturation, with a scoreboard of expected handshakes.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [5:0]  redirect_addr = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [5:0]  if_pc;
  logic        halted;
  logic [15:0] fetch_count;

  // Second instance with a 4-bit counter, always ready, never redirected.
  logic [5:0]  imem_addr2;
  logic [31:0] imem_rdata2;
  logic        if_valid2;
  logic [31:0] if_instr2;
  logic [5:0]  if_pc2;
  logic        halted2;
  logic [3:0]  fetch_count2;

  logic [31:0] mem [64];

  int nchk = 0;
  int nfail = 0;

  typedef struct {
    logic [5:0]  pc;
    logic [31:0] instr;
  } item_t;
  item_t sb[$];

  typedef struct {
    logic       rdy;
    logic       rv;
    logic [5:0] ra;
    logic       ev;
    logic [5:0] epc;
    logic [5:0] eaddr;
  } vec_t;
  vec_t tbl[15];

  always #5 clk = ~clk;

  assign imem_rdata  = mem[imem_addr];
  assign imem_rdata2 = 32'h1000_0000 + 32'(imem_addr2);

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .halted(halted), .fetch_count(fetch_count)
  );

  instruction_fetch_unit #(.CWIDTH(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .redirect_valid(1'b0), .redirect_addr(6'd0),
    .if_valid(if_valid2), .if_ready(1'b1), .if_instr(if_instr2),
    .if_pc(if_pc2), .halted(halted2), .fetch_count(fetch_count2)
  );

  function automatic logic [31:0] word(int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic push(int pc, logic [31:0] w);
    item_t e;
    e.pc = 6'(pc);
    e.instr = w;
    sb.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake must match the next expected {pc, instr}.
  always @(negedge clk) begin : mon
    item_t e;
    if (rst_n && if_valid && if_ready) begin
      if (sb.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL sb_unexpected: got handshake pc %0d, none expected", if_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", 32'(if_pc), 32'(e.pc));
        chk("sb_instr", if_instr, e.instr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = word(i);

    // Stall/redirect vectors, applied from state: pc1 valid, pc=2, not ready.
    tbl[0]  = '{rdy:1'b0, rv:1'b1, ra:6'd5,  ev:1'b0, epc:6'd0,  eaddr:6'd5};
    tbl[1]  = '{rdy:1'b0, rv:1'b0, ra:6'd0,  ev:1'b1, epc:6'd5,  eaddr:6'd6};
    tbl[2]  = '{rdy:1'b0, rv:1'b0, ra:6'd0,  ev:1'b1, epc:6'd5,  eaddr:6'd6};
    tbl[3]  = '{rdy:1'b0, rv:1'b0, ra:6'd0,  ev:1'b1, epc:6'd5,  eaddr:6'd6};
    tbl[4]  = '{rdy:1'b0, rv:1'b0, ra:6'd0,  ev:1'b1, epc:6'd5,  eaddr:6'd6};
    tbl[5]  = '{rdy:1'b1, rv:1'b0, ra:6'd0,  ev:1'b1, epc:6'd6,  eaddr:6'd7};
    tbl[6]  = '{rdy:1'b1, rv:1'b0, ra:6'd0,  ev:1'b1, epc:6'd7,  eaddr:6'd8};
    tbl[7]  = '{rdy:1'b1, rv:1'b0, ra:6'd0,  ev:1'b1, epc:6'd8,  eaddr:6'd9};
    tbl[8]  = '{rdy:1'b1, rv:1'b0, ra:6'd0,  ev:1'b1, epc:6'd9,  eaddr:6'd10};
    tbl[9]  = '{rdy:1'b1, rv:1'b0, ra:6'd0,  ev:1'b1, epc:6'd10, eaddr:6'd11};
    tbl[10] = '{rdy:1'b0, rv:1'b0, ra:6'd0,  ev:1'b1, epc:6'd10, eaddr:6'd11};
    tbl[11] = '{rdy:1'b0, rv:1'b1, ra:6'd40, ev:1'b0, epc:6'd0,  eaddr:6'd40};
    tbl[12] = '{rdy:1'b0, rv:1'b0, ra:6'd0,  ev:1'b1, epc:6'd40, eaddr:6'd41};
    tbl[13] = '{rdy:1'b1, rv:1'b0, ra:6'd0,  ev:1'b1, epc:6'd41, eaddr:6'd42};
    tbl[14] = '{rdy:1'b0, rv:1'b0, ra:6'd0,  ev:1'b1, epc:6'd41, eaddr:6'd42};

    // Reset state
    if_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_count", 32'(fetch_count), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_pc", 32'(if_pc), 0);
    chk("rst_instr", if_instr, 0);

    // Streaming through the whole memory and wrapping back to 0
    for (int i = 0; i < 64; i++) push(i, word(i));
    push(0, word(0));
    rst_n = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      tick();
      if (k == 1) begin
        chk("first_valid", 32'(if_valid), 1);
        chk("first_pc", 32'(if_pc), 0);
      end
      if (k == 10) chk("c4_count_mid", 32'(fetch_count2), 9);
      if (k == 16) chk("c4_count_sat", 32'(fetch_count2), 15);
      if (k == 20) begin
        chk("c4_count_hold", 32'(fetch_count2), 15);
        chk("c4_pc", 32'(if_pc2), 19);
        chk("c4_instr", if_instr2, word(19));
        chk("c4_valid", 32'(if_valid2), 1);
        chk("c4_halted", 32'(halted2), 0);
      end
    end
    if_ready = 1'b0;
    chk("stream_count", 32'(fetch_count), 65);
    chk("stream_drained", 32'(sb.size()), 0);
    chk("c4_count_end", 32'(fetch_count2), 15);

    // Stall and redirect vectors
    push(5, word(5)); push(6, word(6)); push(7, word(7));
    push(8, word(8)); push(9, word(9)); push(40, word(40));
    for (int i = 0; i < 15; i++) begin
      if_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_addr = tbl[i].ra;
      tick();
      redirect_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(tbl[i].eaddr));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_pc", i), 32'(if_pc), 32'(tbl[i].epc));
        chk($sformatf("vec%0d_instr", i), if_instr, word(int'(tbl[i].epc)));
      end
    end
    if_ready = 1'b0;
    chk("vec_count", 32'(fetch_count), 71);
    chk("vec_drained", 32'(sb.size()), 0);

    // Halt at word 7, reached by a redirect that coincides with a handshake
    mem[7] = HALT;
    push(41, word(41));
    for (int i = 0; i < 7; i++) push(i, word(i));
    push(7, HALT);
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 6'd0;
    tick();
    redirect_valid = 1'b0;
    chk("redir_hs_valid", 32'(if_valid), 0);
    chk("redir_hs_count", 32'(fetch_count), 72);
    repeat (8) tick();
    chk("halt_pc", 32'(if_pc), 7);
    chk("halt_instr", if_instr, HALT);
    chk("halt_flag", 32'(halted), 1);
    chk("halt_valid", 32'(if_valid), 1);
    tick();
    chk("halt_drain_valid", 32'(if_valid), 0);
    chk("halt_drain_count", 32'(fetch_count), 80);
    chk("halt_drain_addr", 32'(imem_addr), 8);
    repeat (3) tick();
    chk("halted_valid", 32'(if_valid), 0);
    chk("halted_count", 32'(fetch_count), 80);
    chk("halted_flag", 32'(halted), 1);
    if_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 6'd0;
    tick();
    redirect_valid = 1'b0;
    chk("resume_halted", 32'(halted), 0);
    chk("resume_valid0", 32'(if_valid), 0);
    tick();
    chk("resume_valid", 32'(if_valid), 1);
    chk("resume_pc", 32'(if_pc), 0);
    push(0, word(0));
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    chk("resume_next_pc", 32'(if_pc), 1);
    chk("resume_count", 32'(fetch_count), 81);
    chk("halt_drained", 32'(sb.size()), 0);
    mem[7] = word(7);

    // Asynchronous reset while halted with a word pending
    mem[2] = HALT;
    redirect_valid = 1'b1;
    redirect_addr = 6'd2;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("pre_rst_halted", 32'(halted), 1);
    chk("pre_rst_valid", 32'(if_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(if_valid), 0);
    chk("arst_halted", 32'(halted), 0);
    chk("arst_count", 32'(fetch_count), 0);
    chk("arst_addr", 32'(imem_addr), 0);
    chk("arst_c4_count", 32'(fetch_count2), 0);
    mem[2] = word(2);
    tick();
    rst_n = 1'b1;
    push(0, word(0)); push(1, word(1)); push(2, word(2));
    if_ready = 1'b1;
    tick();
    chk("restart_pc", 32'(if_pc), 0);
    chk("restart_valid", 32'(if_valid), 1);
    repeat (3) tick();
    if_ready = 1'b0;
    chk("restart_count", 32'(fetch_count), 3);
    chk("restart_drained", 32'(sb.size()), 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction memory read interface. Owns the program counter, drives the word address into the asynchronous-read instruction memory, and registers the returned 32-bit word. It presents each word plus its PC to the decode stage through a valid/ready handshake. It also handles control-flow redirects, halts on a designated halt word, and counts delivered instructions.

Parameters:
AWIDTH, 6, word-address width of instruction memory (2**AWIDTH words)
RWIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch
CWIDTH, 16, width of delivered-instruction counter

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  AWIDTH  word address to instruction memory; combinationally equals pc register
imem_rdata  input  RWIDTH  read data from memory; combinational function of imem_addr
redirect_valid  input  1  one-cycle pulse: load new PC, flush pending instruction
redirect_addr  input  AWIDTH  target word address for redirect
if_valid  output  1  if_instr/if_pc hold a valid instruction
if_ready  input  1  decode accepts instruction this cycle
if_instr  output  RWIDTH  registered instruction word
if_pc  output  AWIDTH  address the instruction was fetched from
halted  output  1  fetch unit is in HALTED state
fetch_count  output  CWIDTH  number of completed if_valid&&if_ready handshakes, saturating

Behaviour:
- Reset (rst_n low, asynchronous): pc=RESET_PC, state=RUN, if_valid=0, if_instr=0, if_pc=0, halted=0, fetch_count=0. Reset asserted mid-operation discards the pending instruction immediately.
- States: RUN, HALTED. halted = (state==HALTED).
- Define slot_free = !if_valid || if_ready.
- RUN, slot_free, no redirect, at clock edge:
  - if_instr<=imem_rdata; if_pc<=pc; if_valid<=1; pc<=pc+1.
  - PC wraps modulo 2**AWIDTH: 63 -> 0 at default width.
- RUN, !slot_free: pc, if_instr, if_pc and if_valid all hold. Output stays stable while if_valid && !if_ready.
- Latency: the word at address A appears on if_instr one clock after an edge where pc==A and slot_free.
- First valid output occurs at the first rising edge after rst_n deasserts.
- Sustained throughput is 1 instruction/cycle while if_ready=1.
- Halt:
  - A capture whose imem_rdata==HALT_WORD still delivers the word (if_valid=1) and sets state<=HALTED in the same edge.
  - pc still increments on that edge.
  - In HALTED there are no further captures. if_valid clears after the halt word handshakes, then stays 0.
- Redirect (highest priority, either state):
  - pc<=redirect_addr; if_valid<=0, discarding any unaccepted instruction; state<=RUN.
  - No capture occurs on the redirect edge.
  - Fetch from redirect_addr is captured on the next edge, so the first redirected instruction is valid 2 edges after redirect is sampled.
- Redirect coincident with if_valid&&if_ready: the handshake completes and is counted; the outgoing word is consumed, then flushed.
- fetch_count increments by 1 on each edge with if_valid&&if_ready. It saturates at 2**CWIDTH-1 and does not wrap. It is cleared only by reset.
- imem_rdata is only sampled, never stored unregistered; if_instr is never combinational from imem_rdata.

Decomposition:
- Shared package fetch_pkg: fetch_state_t enum {RUN, HALTED}, localparam HALT_WORD_DEFAULT, IMEM_AWIDTH=6, IMEM_RWIDTH=32. The same package is used by decode and by benches.
- Single module; no sub-module needed.
- Bench reuses the existing Instruction_Memory_32bit as the memory model, with contents word[i]=32'h1000_0000+i except where a scenario places HALT_WORD.

Test Plan:
1. Reset release, if_ready=1, no halt in memory -> if_pc sequence 0,1,2,...,63,0 on consecutive cycles; if_instr=0x1000_0000+if_pc; fetch_count=65 after 65 handshakes.
2. if_ready low for 3 cycles while if_valid=1 showing pc=5 -> if_instr=0x1000_0005 and imem_addr=6 are held stable all 3 cycles; pc=6 is delivered the cycle after if_ready returns; no word is skipped or duplicated.
3. redirect_valid pulse with redirect_addr=40 while if_pc=10 is valid and not ready -> next cycle if_valid=0; the following cycle if_pc=40, if_instr=0x1000_0028; pc 10 is never handshaked.
4. word[7]=HALT_WORD, if_ready=1 -> if_pc 0..7 delivered, halted=1 after the pc=7 capture, if_valid=0 afterwards, fetch_count frozen at 8; then redirect to 0 -> halted=0 and fetch resumes at 0.
5. rst_n pulsed low asynchronously mid-stream between clock edges -> if_valid, halted and fetch_count go 0 immediately without a clock edge; after release, fetch restarts at RESET_PC.
6. CWIDTH overridden to 4, 20 handshakes -> fetch_count reaches 15 and stays at 15.
